imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 118 +++++++++++
 tb/tb_imem_boot_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: assembles a little-endian byte stream
// into 32-bit words, writes them from address 0 and holds the CPU in reset until done.
module imem_boot_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [10:0]   word_count,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   fetch_A,
  output logic [31:0]   fetch_RD,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;        // words written; one bit wider than AW so 1024 is representable
  logic [10:0] count_q, count_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic        count_ok;
  logic        unused_fetch_bits;

  assign count_ok = (word_count != 11'd0) && (word_count <= 11'd1024);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          if (count_ok) begin
            state_d    = S_LOAD;
            cnt_d      = 11'd0;
            count_d    = word_count;
            byte_cnt_d = 2'd0;
            word_d     = 32'h0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          word_d[8*byte_cnt_q +: 8] = byte_data;
          byte_cnt_d                = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 11'd1;
        state_d = (cnt_d == count_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 11'd0;
      count_q    <= 11'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

  assign mem_we    = (state_q == S_WRITE);
  assign mem_waddr = cnt_q[AW-1:0];
  assign mem_wdata = word_q;

  // The pipeline only runs while no session is in flight.
  assign cpu_rst   = rst && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mem_raddr = fetch_A[AW+1:2];
  assign fetch_RD  = cpu_rst ? mem_rdata : 32'h0;

  assign unused_fetch_bits = ^{fetch_A[31:AW+2], fetch_A[1:0]};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares every mem_we cycle.
module tb_imem_boot_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [10:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   fetch_A;
  logic [31:0]   fetch_RD;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  imem_boot_loader #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_A    (fetch_A),
    .fetch_RD   (fetch_RD),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int          model_addr;
  int          compared   = 0;
  int          mismatched = 0;

  // Instruction memory: combinational read, clocked write.
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(mem_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_waddr), 32'(e.addr));
        check("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [10:0] wc);
    load_start = 1'b1;
    word_count = wc;
    tick();
    load_start = 1'b0;
    word_count = 11'(($urandom));
    if (wc != 0 && wc <= 11'd1024) model_addr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n          = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (!byte_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  // Reference view: a word is its four bytes concatenated little-endian.
  task automatic send_word(input logic [31:0] w, input int max_gap);
    wr_t e;
    e.addr = AW'(model_addr);
    e.data = w;
    exp_q.push_back(e);
    ref_mem[model_addr] = w;
    model_addr++;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(max_gap, 0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      n++;
      @(negedge clk);
    end
    check("done", 32'(done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("cpu_rst_after_done", 32'(cpu_rst), 32'd1);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    rst        = 1'b0;
    load_start = 1'b0;
    word_count = 11'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h0;
    fetch_A    = 32'h0;
    model_addr = 0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);

    // Two-word directed load, with fetch blanking while loading
    start(11'd2);
    fetch_A = 32'h8;
    #1;
    check("load_raddr", 32'(mem_raddr), 32'd2);
    check("load_fetch_rd", fetch_RD, 32'h0);
    check("load_cpu_rst", 32'(cpu_rst), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    send_word(32'h00A0_0093, 0);
    send_word(32'h00A0_0113, 0);
    wait_done(50);
    check("mem0", mem[0], 32'h00A0_0093);
    fetch_A = 32'h4;
    #1;
    check("done_fetch_rd", fetch_RD, ref_mem[1]);
    fetch_A = 32'h7;
    #1;
    check("done_fetch_rd_lowbits", fetch_RD, ref_mem[1]);

    // Single word with one idle cycle between bytes
    start(11'd1);
    send_word(32'hCAFE_F00D, 1);
    wait_done(50);

    // Illegal counts: err set, no session started
    start(11'd0);
    check("err_wc0", 32'(err), 32'd1);
    check("err_wc0_busy", 32'(busy), 32'd0);
    check("err_wc0_done_kept", 32'(done), 32'd1);
    start(11'd1025);
    check("err_wc1025", 32'(err), 32'd1);
    check("err_wc1025_ready", 32'(byte_ready), 32'd0);
    start(11'd1);
    check("err_cleared", 32'(err), 32'd0);
    check("done_cleared", 32'(done), 32'd0);
    send_word(32'h1234_5678, 0);
    wait_done(50);

    // load_start mid-LOAD ignored
    start(11'd3);
    send_word(32'h1111_1111, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    start(11'd1);
    model_addr = 2;
    begin
      wr_t e;
      e.addr = AW'(1);
      e.data = 32'h22_11_BB_AA;
      exp_q.push_back(e);
      ref_mem[1] = e.data;
    end
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_word(32'h3333_3333, 0);
    wait_done(50);

    // Randomized sessions; bytes offered in DONE must be ignored
    for (int s = 0; s < 6; s++) begin
      int wc;
      wc = $urandom_range(6, 1);
      start(11'(wc));
      for (int w = 0; w < wc; w++) send_word($urandom, 2);
      wait_done(100);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      repeat (3) tick();
      byte_valid = 1'b0;
      check("done_hold", 32'(done), 32'd1);
    end

    // Reset mid-session: words 0-2 kept, partial word 3 dropped
    start(11'd5);
    for (int w = 0; w < 3; w++) send_word($urandom, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    #3;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_release_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_release_busy", 32'(busy), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    for (int w = 0; w < 3; w++) check("abort_mem_intact", mem[w], ref_mem[w]);
    tick();

    // Full 1024-word load: no 1025th write
    start(11'd1024);
    for (int w = 0; w < 1024; w++) send_word($urandom, 0);
    wait_done(50);
    check("full_last_word", mem[1023], ref_mem[1023]);
    check("full_first_word", mem[0], ref_mem[0]);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
